prog_mem: RTL and testbench

// - Memory responder for the tiny CPU bus: answers addr/write/wdata with rdata; no wait states.
// - Owns program loading: holds the CPU in reset, accepts program bytes over a valid/ready stream, then releases the CPU.
// - Sits beside the CPU in the top level; its cpu_rst drives the CPU's rst.

---
 rtl/tiny_pkg.sv | 18 +
 rtl/mem_array.sv | 22 ++
 rtl/prog_mem.sv | 123 ++++++++++++
 tb/tb_prog_mem.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tiny_pkg.sv
// Shared types for the tiny CPU system: loader/memory state and CPU opcode values.
package tiny_pkg;

  typedef enum logic [1:0] {
    idle = 2'd0,
    load = 2'd1,
    run  = 2'd2
  } mem_state_type;

  // Opcode values shared with the CPU so program images can be built symbolically.
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [7:0] OP_LDA = 8'h01;
  localparam logic [7:0] OP_STA = 8'h02;
  localparam logic [7:0] OP_ADD = 8'h03;
  localparam logic [7:0] OP_JMP = 8'h04;
  localparam logic [7:0] OP_HLT = 8'hff;

endpackage

// File: rtl/mem_array.sv
// Byte-addressed storage: one combinational read port, one synchronous write port, no reset.
module mem_array #(
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [addr_width-1:0] waddr,
  input  logic [data_width-1:0] wdata,
  input  logic [addr_width-1:0] raddr,
  output logic [data_width-1:0] rdata
);

  logic [data_width-1:0] mem [2**addr_width];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_mem.sv
// Program memory with built-in stream loader that holds the CPU in reset until loaded.
// Optional memory-mapped output register at IO_ADDR when PROG_MEM_MMIO_EN is defined.
//
// state | meaning
// idle  | after reset; CPU held in reset, loader not ready
// load  | accepting loader bytes into mem[ptr]; CPU held in reset
// run   | CPU released; CPU bus may write the array
module prog_mem
  import tiny_pkg::*;
#(
  parameter int addr_width = 8,
  parameter int data_width = 8,
  parameter logic [addr_width-1:0] IO_ADDR = {addr_width{1'b1}}
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [addr_width-1:0] addr,
  input  logic                  write,
  input  logic [data_width-1:0] wdata,
  output logic [data_width-1:0] rdata,
  input  logic                  ld_start,
  input  logic                  ld_valid,
  input  logic [data_width-1:0] ld_data,
  input  logic                  ld_last,
  output logic                  ld_ready,
  output logic                  cpu_rst,
  output logic [addr_width:0]   ld_count,
  output logic [data_width-1:0] io_out,
  output logic                  io_strobe
);

`ifdef PROG_MEM_MMIO_EN
  localparam bit mmio_en = 1'b1;
`else
  localparam bit mmio_en = 1'b0;
`endif

  mem_state_type state_q, state_d;
  logic [addr_width-1:0] ptr_q;
  logic [addr_width:0]   count_q;
  logic                  accept, last_byte, io_hit;
  logic                  arr_we;
  logic [addr_width-1:0] arr_waddr;
  logic [data_width-1:0] arr_wdata, arr_rdata;

  assign io_hit    = mmio_en && (addr == IO_ADDR);
  assign accept    = ld_valid && (state_q == load);
  assign last_byte = ld_last || (ptr_q == {addr_width{1'b1}});

  always_comb begin
    state_d = state_q;
    case (state_q)
      idle:    if (ld_start) state_d = load;
      load:    if (accept && last_byte) state_d = run;
      run:     if (ld_start) state_d = load;
      default: state_d = idle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= idle;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      // ld_start is ignored while loading, so only idle/run restart the pointer.
      if (ld_start && (state_q != load)) begin
        ptr_q   <= '0;
        count_q <= '0;
      end else if (accept) begin
        ptr_q   <= ptr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
    end
  end

  always_comb begin
    arr_we    = 1'b0;
    arr_waddr = addr;
    arr_wdata = wdata;
    if (state_q == load) begin
      arr_we    = accept;
      arr_waddr = ptr_q;
      arr_wdata = ld_data;
    end else if (state_q == run) begin
      arr_we = write && !io_hit;
    end
  end

  mem_array #(
    .addr_width(addr_width),
    .data_width(data_width)
  ) u_mem_array (
    .clk  (clk),
    .we   (arr_we),
    .waddr(arr_waddr),
    .wdata(arr_wdata),
    .raddr(addr),
    .rdata(arr_rdata)
  );

`ifdef PROG_MEM_MMIO_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      io_out    <= '0;
      io_strobe <= 1'b0;
    end else begin
      io_strobe <= write && io_hit && (state_q == run);
      if (write && io_hit && (state_q == run)) io_out <= wdata;
    end
  end
`else
  assign io_out    = '0;
  assign io_strobe = 1'b0;
`endif

  assign rdata    = io_hit ? io_out : arr_rdata;
  assign ld_ready = (state_q == load);
  assign cpu_rst  = (state_q != run);
  assign ld_count = count_q;

endmodule

// File: tb/tb_prog_mem.sv
// Self-checking bench for prog_mem: directed steps plus randomized loads/writes against an array model.
module tb_prog_mem;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] addr;
  logic       write;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic       ld_start, ld_valid, ld_last;
  logic [7:0] ld_data;
  logic       ld_ready, cpu_rst;
  logic [8:0] ld_count;
  logic [7:0] io_out;
  logic       io_strobe;

  int total = 0;
  int bad   = 0;

  logic [7:0] model_mem [256];
  logic [7:0] exp_io = 8'h00;
  logic [7:0] lq [$];
  int         wr_addrs [$];

  prog_mem dut (
    .clk      (clk),
    .rst      (rst),
    .addr     (addr),
    .write    (write),
    .wdata    (wdata),
    .rdata    (rdata),
    .ld_start (ld_start),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_last  (ld_last),
    .ld_ready (ld_ready),
    .cpu_rst  (cpu_rst),
    .ld_count (ld_count),
    .io_out   (io_out),
    .io_strobe(io_strobe)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] exp_rd(input int a);
`ifdef PROG_MEM_MMIO_EN
    if (a == 255) return exp_io;
`endif
    return model_mem[a];
  endfunction

  task automatic rd(input string tag, input int a);
    addr = 8'(a);
    #1;
    chk($sformatf("%s@%0d", tag, a), 32'(rdata), 32'(exp_rd(a)));
  endtask

  // Load the bytes in lq; model memory follows the loader pointer from 0.
  task automatic do_load(input string tag, input bit use_last, input int stall_idx,
                         input bit rnd_stall);
    int n;
    n = lq.size();
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk({tag, "_ready"}, 32'(ld_ready), 32'd1);
    chk({tag, "_cnt0"}, 32'(ld_count), 32'd0);
    for (int i = 0; i < n; i++) begin
      int ns;
      ns = 0;
      if (i == stall_idx) ns = 3;
      else if (rnd_stall && ($urandom_range(0, 3) == 0)) ns = int'($urandom_range(1, 2));
      for (int s = 0; s < ns; s++) begin
        ld_valid = 1'b0;
        ld_data  = 8'($urandom);
        tick();
        chk({tag, "_stall_cnt"}, 32'(ld_count), 32'(i));
        chk({tag, "_stall_rst"}, 32'(cpu_rst), 32'd1);
      end
      ld_valid = 1'b1;
      ld_data  = lq[i];
      ld_last  = use_last && (i == n - 1);
      if (i == n - 1) chk({tag, "_pre_last_rst"}, 32'(cpu_rst), 32'd1);
      tick();
      model_mem[i % 256] = lq[i];
    end
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    chk({tag, "_count"}, 32'(ld_count), 32'(n));
    chk({tag, "_cpu_rst"}, 32'(cpu_rst), 32'd0);
    chk({tag, "_ready_off"}, 32'(ld_ready), 32'd0);
  endtask

  task automatic cpu_wr(input int a, input logic [7:0] d, input bit in_run);
    addr  = 8'(a);
    wdata = d;
    write = 1'b1;
    tick();
    write = 1'b0;
    if (in_run) begin
`ifdef PROG_MEM_MMIO_EN
      if (a == 255) exp_io = d;
      else model_mem[a] = d;
`else
      model_mem[a] = d;
`endif
    end
  endtask

  initial begin
    int a, n;
    logic [7:0] d;
    rst = 1'b1; addr = '0; write = 1'b0; wdata = '0;
    ld_start = 1'b0; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Idle after reset, no stimulus.
    for (int i = 0; i < 10; i++) begin
      chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      chk("rst_ld_ready", 32'(ld_ready), 32'd0);
      chk("rst_ld_count", 32'(ld_count), 32'd0);
      chk("rst_io_strobe", 32'(io_strobe), 32'd0);
      tick();
    end

    // Directed load with a 3-cycle stall before the third byte.
    lq = '{8'd1, 8'd5, 8'd5, 8'd200, 8'd10};
    do_load("load5", 1'b1, 2, 1'b0);
    rd("load5_rd", 1);
    for (int i = 0; i < 5; i++) rd("load5_all", i);

    // RUN write lands next cycle.
    cpu_wr(200, 8'd5, 1'b1);
    rd("run_wr200", 200);
    cpu_wr(150, 8'h5a, 1'b1);

    // Writes while loading are dropped; ld_start during LOAD is ignored.
    ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    addr = 8'd150; wdata = 8'ha5; write = 1'b1;
    tick();
    write = 1'b0;
    ld_valid = 1'b1; ld_data = 8'h11;
    tick();
    ld_valid = 1'b0; ld_start = 1'b1;
    tick();
    ld_start = 1'b0;
    chk("ignore_start_cnt", 32'(ld_count), 32'd1);
    chk("ignore_start_ready", 32'(ld_ready), 32'd1);
    ld_valid = 1'b1; ld_data = 8'h22; ld_last = 1'b1;
    tick();
    ld_valid = 1'b0; ld_last = 1'b0;
    model_mem[0] = 8'h11; model_mem[1] = 8'h22;
    chk("ignore_start_cnt2", 32'(ld_count), 32'd2);
    chk("ignore_start_run", 32'(cpu_rst), 32'd0);
    rd("load_wr_drop", 150);
    rd("ignore_start_rd", 0);
    rd("ignore_start_rd", 1);

    // Randomized loads with random stalls, then random CPU traffic.
    for (int k = 0; k < 3; k++) begin
      n = int'($urandom_range(3, 20));
      lq.delete();
      for (int i = 0; i < n; i++) lq.push_back(8'($urandom));
      do_load("rnd_load", 1'b1, -1, 1'b1);
      for (int i = 0; i < n; i++) rd("rnd_load_rd", i);
    end
    wr_addrs.delete();
    for (int k = 0; k < 12; k++) begin
      a = int'($urandom_range(0, 254));
      d = 8'($urandom);
      cpu_wr(a, d, 1'b1);
      wr_addrs.push_back(a);
    end
    foreach (wr_addrs[j]) rd("rnd_wr_rd", wr_addrs[j]);

    // ld_start and CPU write in the same RUN cycle: both take effect.
    addr = 8'd210; wdata = 8'h33; write = 1'b1; ld_start = 1'b1;
    tick();
    write = 1'b0; ld_start = 1'b0;
    model_mem[210] = 8'h33;
    chk("start_wr_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("start_wr_ready", 32'(ld_ready), 32'd1);
    chk("start_wr_cnt", 32'(ld_count), 32'd0);
    rd("start_wr_rd", 210);

    // Reset in the middle of a load keeps written bytes.
    ld_valid = 1'b1; ld_data = 8'ha1;
    tick();
    ld_data = 8'ha2;
    tick();
    ld_valid = 1'b0;
    model_mem[0] = 8'ha1; model_mem[1] = 8'ha2;
    chk("mid_cnt2", 32'(ld_count), 32'd2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_cnt", 32'(ld_count), 32'd0);
    chk("mid_rst_ready", 32'(ld_ready), 32'd0);
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    rd("mid_rst_keep", 0);
    rd("mid_rst_keep", 1);

    // CPU write in IDLE is dropped.
    cpu_wr(200, 8'h77, 1'b0);
    rd("idle_wr_drop", 200);

    lq = '{8'h10, 8'h20, 8'h30, 8'h40, 8'h50};
    do_load("reload", 1'b1, -1, 1'b0);
    for (int i = 0; i < 5; i++) rd("reload_rd", i);

    // Output register at the top address (ordinary memory without MMIO).
    cpu_wr(255, 8'h42, 1'b1);
`ifdef PROG_MEM_MMIO_EN
    chk("io_out", 32'(io_out), 32'h42);
    chk("io_strobe_hi", 32'(io_strobe), 32'd1);
`else
    chk("io_out", 32'(io_out), 32'h0);
    chk("io_strobe_hi", 32'(io_strobe), 32'd0);
`endif
    tick();
    chk("io_strobe_lo", 32'(io_strobe), 32'd0);
    rd("io_rd", 255);

    // Full-depth load without ld_last ends in RUN with count = depth.
    lq.delete();
    for (int i = 0; i < 256; i++) lq.push_back(8'($urandom));
    do_load("full", 1'b0, -1, 1'b0);
    for (int k = 0; k < 16; k++) rd("full_rd", int'($urandom_range(0, 255)));
    rd("full_rd_top", 255);
    rd("full_rd_bot", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
